// File: rtl/lab4e_pkg.sv
// Shared types and defaults for the lab4e serial subtractor.
// The full-adder helper is the single cell the ripple slice is built from.
package lab4e_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int SLICE_DEF = 8;

  // Returns {carry_out, sum} for one bit position.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    full_add = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/lab4e_slice.sv
// Combinational SLICE-bit ripple adder built from a chain of full-adder cells.
module lab4e_slice
  import lab4e_pkg::*;
#(
  parameter int SLICE = SLICE_DEF
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             ci,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_fa
    assign {w_c[i+1], s[i]} = full_add(a[i], b[i], w_c[i]);
  end

  assign co = w_c[SLICE];

endmodule

// File: rtl/lab4e_serial_sub.sv
// Multi-cycle subtractor: fdiff = xin - yin - bzin computed one SLICE per clock
// by adding the inverted subtrahend, with borrow, signed-overflow and zero flags.
module lab4e_serial_sub
  import lab4e_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] xin,
  input  logic [WIDTH-1:0] yin,
  input  logic             bzin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] fdiff,
  output logic             fbout,
  output logic             fovf,
  output logic             fzero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_fdiff;
  logic             r_fbout;
  logic             r_fovf;
  logic             r_fzero;

  logic [SLICE-1:0] w_xs;
  logic [SLICE-1:0] w_ys;
  logic [SLICE-1:0] w_sum;
  logic             w_co;
  logic [WIDTH-1:0] w_full;
  logic             w_accept;
  logic             w_last;
  logic             w_ovf;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_k == K_LAST);

  // Select the active slice of the operands; the subtrahend enters inverted.
  always_comb begin
    w_xs = '0;
    w_ys = '0;
    for (int i = 0; i < NSLICE; i++) begin
      w_xs = (r_k == KW'(i)) ? r_x[i*SLICE +: SLICE]  : w_xs;
      w_ys = (r_k == KW'(i)) ? ~r_y[i*SLICE +: SLICE] : w_ys;
    end
  end

  lab4e_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a  (w_xs),
    .b  (w_ys),
    .ci (r_carry),
    .s  (w_sum),
    .co (w_co)
  );

  // Partial result with the slice being computed this cycle merged in.
  always_comb begin
    w_full = r_part;
    for (int i = 0; i < NSLICE; i++) begin
      w_full[i*SLICE +: SLICE] = (r_k == KW'(i)) ? w_sum : r_part[i*SLICE +: SLICE];
    end
  end

  // Operands with equal signs whose sum flips sign: carry into MSB != carry out.
  assign w_ovf = (w_xs[SLICE-1] == w_ys[SLICE-1]) && (w_sum[SLICE-1] != w_xs[SLICE-1]);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? RUN : IDLE;
      RUN:     w_next = w_last ? DONE : RUN;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == RUN);
      r_done  <= (w_next == DONE);
    end
  end

  // Operand capture and slice-by-slice accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
    end else if (w_accept) begin
      r_x     <= xin;
      r_y     <= yin;
      r_part  <= '0;
      r_carry <= ~bzin;
      r_k     <= '0;
    end else if (r_state == RUN) begin
      r_part  <= w_full;
      r_carry <= w_co;
      r_k     <= w_last ? '0 : r_k + KW'(1);
    end else begin
      r_k     <= r_k;
    end
  end

  // Results are published only on the final slice, so nothing partial leaks out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fdiff <= '0;
      r_fbout <= 1'b0;
      r_fovf  <= 1'b0;
      r_fzero <= 1'b0;
    end else if (w_last) begin
      r_fdiff <= w_full;
      r_fbout <= ~w_co;
      r_fovf  <= w_ovf;
      r_fzero <= (w_full == '0);
    end else begin
      r_fdiff <= r_fdiff;
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign fdiff = r_fdiff;
  assign fbout = r_fbout;
  assign fovf  = r_fovf;
  assign fzero = r_fzero;

endmodule

// File: tb/tb_lab4e_serial_sub.sv
// Scoreboard bench for lab4e_serial_sub: expected results are queued at issue
// time and popped when done pulses.
module tb_lab4e_serial_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] xin;
  logic [15:0] yin;
  logic        bzin;
  logic        busy;
  logic        done;
  logic [15:0] fdiff;
  logic        fbout;
  logic        fovf;
  logic        fzero;

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        o;
    logic        z;
  } res_t;

  res_t sb[$];
  res_t last_res;
  int   n_tests = 0;
  int   n_fail  = 0;

  lab4e_serial_sub dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .xin   (xin),
    .yin   (yin),
    .bzin  (bzin),
    .busy  (busy),
    .done  (done),
    .fdiff (fdiff),
    .fbout (fbout),
    .fovf  (fovf),
    .fzero (fzero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic bz);
    logic [16:0] s;
    int          r;
    res_t        m;
    s   = {1'b0, x} + {1'b0, ~y} + {16'd0, ~bz};
    r   = int'($signed(x)) - int'($signed(y)) - int'(bz);
    m.d = s[15:0];
    m.b = ~s[16];
    m.o = (r > 32767) || (r < -32768);
    m.z = (s[15:0] == 16'd0);
    return m;
  endfunction

  function automatic res_t observed();
    res_t g;
    g.d = fdiff;
    g.b = fbout;
    g.o = fovf;
    g.z = fzero;
    return g;
  endfunction

  // Drive start for one edge from a negedge, then scramble the operand inputs.
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic bz);
    xin   = x;
    yin   = y;
    bzin  = bz;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    xin   = 16'($urandom);
    yin   = 16'($urandom);
    bzin  = 1'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    xin   = 16'h1234;
    yin   = 16'h0234;
    bzin  = 1'b0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    n_tests++;
    if ({busy, done, observed()} !== {2'b00, 19'd0}) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b fdiff=%h b=%b o=%b z=%b want all 0",
               busy, done, fdiff, fbout, fovf, fzero);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle[%0d] got busy=%b done=%b want 0 0", i, busy, done);
      end
    end
    last_res = '0;
  endtask

  task automatic test_directed();
    logic [15:0] xs [4] = '{16'h1234, 16'h0000, 16'h8000, 16'h0100};
    logic [15:0] ys [4] = '{16'h0234, 16'h0001, 16'h0001, 16'h00FF};
    logic        bs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    res_t        es [4] = '{{16'h1000, 1'b0, 1'b0, 1'b0},
                            {16'hFFFF, 1'b1, 1'b0, 1'b0},
                            {16'h7FFF, 1'b0, 1'b1, 1'b0},
                            {16'h0000, 1'b0, 1'b0, 1'b1}};
    int   cyc;
    res_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(es[i]);
      issue(xs[i], ys[i], bs[i]);
      wait_done(cyc);
      n_tests++;
      if (cyc != 2) begin
        n_fail++;
        $display("FAIL dir%0d_latency got %0d cycles want 2", i, cyc);
      end
      e = sb.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL dir%0d_result got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b z=%b",
                 i, fdiff, fbout, fovf, fzero, e.d, e.b, e.o, e.z);
      end
      last_res = e;
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL dir%0d_pulse got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int   cyc;
    res_t e;
    sb.push_back(model(16'h1234, 16'h0234, 1'b0));
    issue(16'h1234, 16'h0234, 1'b0);
    n_tests++;
    if (observed() !== last_res || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold0 got d=%h busy=%b want d=%h busy=1", fdiff, busy, last_res.d);
    end
    xin   = 16'hFFFF;
    yin   = 16'h0001;
    bzin  = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (observed() !== last_res) begin
      n_fail++;
      $display("FAIL busy_hold1 got d=%h want d=%h", fdiff, last_res.d);
    end
    wait_done(cyc);
    n_tests++;
    if (cyc != 1) begin
      n_fail++;
      $display("FAIL busy_latency got %0d more cycles want 1", cyc);
    end
    e = sb.pop_front();
    n_tests++;
    if (observed() !== e) begin
      n_fail++;
      $display("FAIL busy_result got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b z=%b",
               fdiff, fbout, fovf, fzero, e.d, e.b, e.o, e.z);
    end
    last_res = e;
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs [2] = '{16'hA5A5, 16'h0001};
    logic [15:0] ys [2] = '{16'h5A5A, 16'h8000};
    int   cyc;
    res_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(model(xs[i], ys[i], 1'b1));
      issue(xs[i], ys[i], 1'b1);
      wait_done(cyc);
      n_tests++;
      if (cyc != 2) begin
        n_fail++;
        $display("FAIL b2b%0d_latency got %0d cycles want 2", i, cyc);
      end
      e = sb.pop_front();
      n_tests++;
      if (observed() !== e) begin
        n_fail++;
        $display("FAIL b2b%0d_result got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b z=%b",
                 i, fdiff, fbout, fovf, fzero, e.d, e.b, e.o, e.z);
      end
      last_res = e;
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    issue(16'h4321, 16'h1234, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    n_tests++;
    if ({busy, done, observed()} !== {2'b00, 19'd0}) begin
      n_fail++;
      $display("FAIL abort_state got busy=%b done=%b fdiff=%h b=%b o=%b z=%b want all 0",
               busy, done, fdiff, fbout, fovf, fzero);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL abort_nodone got %0d done pulses want 0", seen);
    end
    last_res = '0;
  endtask

  task automatic test_random();
    logic [15:0] x;
    logic [15:0] y;
    logic        bz;
    int          cyc;
    res_t        e;
    for (int i = 0; i < 2000; i++) begin
      x  = 16'($urandom);
      y  = ($urandom_range(0, 7) == 0) ? x : 16'($urandom);
      bz = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'($urandom);
      if ($urandom_range(0, 15) == 0) x = 16'h8000;
      sb.push_back(model(x, y, bz));
      issue(x, y, bz);
      wait_done(cyc);
      e = sb.pop_front();
      n_tests++;
      if (cyc < 0 || observed() !== e) begin
        n_fail++;
        $display("FAIL rnd%0d x=%h y=%h bz=%b cyc=%0d got d=%h b=%b o=%b z=%b want d=%h b=%b o=%b z=%b",
                 i, x, y, bz, cyc, fdiff, fbout, fovf, fzero, e.d, e.b, e.o, e.z);
      end
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    xin   = 16'd0;
    yin   = 16'd0;
    bzin  = 1'b0;
    last_res = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
